// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks: sequencer states,
// register-address width and the load-use detection helper.
package pipe_ctrl_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic {
      RUN        = 1'b0,
      REDIR_PEND = 1'b1
   } pipe_state_e;

   // The load result is not forwardable until after MEM, so any consumer in ID
   // of a non-zero load destination must wait one cycle.
   function automatic logic load_use_hit(
      input logic                  mem_read,
      input logic [REG_ADDR_W-1:0] rd,
      input logic [REG_ADDR_W-1:0] rs1,
      input logic [REG_ADDR_W-1:0] rs2,
      input logic                  use_rs1,
      input logic                  use_rs2
   );
      return mem_read && (rd != REG_ZERO) &&
             ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard sequencer bus: hazard inputs from the pipeline stages and the
// per-stage enable/flush controls returned to them.
interface hazard_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int PERF_W = 32
);
   logic [REG_ADDR_W-1:0] ifid_rs1;
   logic [REG_ADDR_W-1:0] ifid_rs2;
   logic                  ifid_use_rs1;
   logic                  ifid_use_rs2;
   logic                  idex_mem_read;
   logic [REG_ADDR_W-1:0] idex_rd;
   logic                  ex_redirect;
   logic [XLEN-1:0]       ex_redirect_target;
   logic                  imem_ready;
   logic                  exmem_mem_req;
   logic                  dmem_ready;

   logic                  pc_write;
   logic                  pc_redirect;
   logic [XLEN-1:0]       pc_target;
   logic                  ifid_write;
   logic                  idex_write;
   logic                  exmem_write;
   logic                  ifid_flush;
   logic                  idex_flush;
   logic                  memwb_flush;
   logic                  mem_timeout;
   logic [PERF_W-1:0]     stall_cnt;
   logic [PERF_W-1:0]     flush_cnt;
   logic [PERF_W-1:0]     load_use_cnt;

   modport master (
      output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
             idex_mem_read, idex_rd, ex_redirect, ex_redirect_target,
             imem_ready, exmem_mem_req, dmem_ready,
      input  pc_write, pc_redirect, pc_target, ifid_write, idex_write,
             exmem_write, ifid_flush, idex_flush, memwb_flush, mem_timeout,
             stall_cnt, flush_cnt, load_use_cnt
   );

   modport slave (
      input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
             idex_mem_read, idex_rd, ex_redirect, ex_redirect_target,
             imem_ready, exmem_mem_req, dmem_ready,
      output pc_write, pc_redirect, pc_target, ifid_write, idex_write,
             exmem_write, ifid_flush, idex_flush, memwb_flush, mem_timeout,
             stall_cnt, flush_cnt, load_use_cnt
   );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating performance counters for the hazard sequencer: stall cycles,
// redirect flushes and load-use stalls.
module hazard_perf_cnt #(
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_inc,
   input  logic              flush_inc,
   input  logic              lu_inc,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt,
   output logic [PERF_W-1:0] load_use_cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt    <= '0;
         flush_cnt    <= '0;
         load_use_cnt <= '0;
      end else begin
         if (stall_inc && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (flush_inc && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
         if (lu_inc && (load_use_cnt != '1))
            load_use_cnt <= load_use_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard sequencer: load-use, EX redirect, imem and dmem waits.
// Define HAZARD_PERF_EN to build the saturating performance counters.
//
// state      | meaning
// RUN        | normal flow; redirects applied directly when IF can take them
// REDIR_PEND | redirect target held in tgq until IF accepts it
module hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = 255,
   parameter int PERF_W      = 32
) (
   input logic         clk,
   input logic         rst,
   hazard_ctrl_if.slave bus
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

   pipe_state_e       state_q, state_d;
   logic [XLEN-1:0]   tgq, tgq_d;
   logic [WAIT_W-1:0] wait_cnt;
   logic              mem_timeout_q;

   logic              dstall, lu;
   logic              pc_write, pc_redirect;
   logic [XLEN-1:0]   pc_target;
   logic              ifid_write, idex_write, exmem_write;
   logic              ifid_flush, idex_flush, memwb_flush;

   assign dstall = bus.exmem_mem_req & ~bus.dmem_ready;
   assign lu     = load_use_hit(bus.idex_mem_read, bus.idex_rd, bus.ifid_rs1,
                                bus.ifid_rs2, bus.ifid_use_rs1, bus.ifid_use_rs2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         tgq     <= '0;
      end else begin
         state_q <= state_d;
         tgq     <= tgq_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tgq_d       = tgq;
      pc_write    = 1'b1;
      pc_redirect = 1'b0;
      pc_target   = '0;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;

      if (rst) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         memwb_flush = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               // A dmem wait freezes EX, so the redirect/load-use it holds reappears next cycle.
               if (dstall) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_write  = 1'b0;
                  exmem_write = 1'b0;
                  memwb_flush = 1'b1;
               end else if (bus.ex_redirect) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  if (bus.imem_ready) begin
                     pc_redirect = 1'b1;
                     pc_target   = bus.ex_redirect_target;
                  end else begin
                     pc_write = 1'b0;
                     tgq_d    = bus.ex_redirect_target;
                     state_d  = REDIR_PEND;
                  end
               end else if (lu) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  idex_flush = 1'b1;
               end else if (!bus.imem_ready) begin
                  pc_write   = 1'b0;
                  ifid_flush = 1'b1;
               end
            end
            REDIR_PEND: begin
               pc_redirect = 1'b1;
               pc_target   = tgq;
               ifid_flush  = 1'b1;
               if (bus.ex_redirect)
                  tgq_d = bus.ex_redirect_target;
               if (dstall) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_write  = 1'b0;
                  exmem_write = 1'b0;
                  memwb_flush = 1'b1;
               end else begin
                  pc_write = bus.imem_ready;
                  if (bus.imem_ready)
                     state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt      <= '0;
         mem_timeout_q <= 1'b0;
      end else if (dstall) begin
         if (wait_cnt != '1)
            wait_cnt <= wait_cnt + 1'b1;
         if ((MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)))
            mem_timeout_q <= 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end

`ifdef HAZARD_PERF_EN
   logic stall_inc, flush_inc, lu_inc;

   assign stall_inc = ~rst & ~pc_write;
   assign flush_inc = ~rst & (state_q == RUN) & ~dstall & bus.ex_redirect;
   assign lu_inc    = ~rst & (state_q == RUN) & ~dstall & ~bus.ex_redirect & lu;

   hazard_perf_cnt #(
      .PERF_W(PERF_W)
   ) u_perf (
      .clk         (clk),
      .rst         (rst),
      .stall_inc   (stall_inc),
      .flush_inc   (flush_inc),
      .lu_inc      (lu_inc),
      .stall_cnt   (bus.stall_cnt),
      .flush_cnt   (bus.flush_cnt),
      .load_use_cnt(bus.load_use_cnt)
   );
`else
   assign bus.stall_cnt    = '0;
   assign bus.flush_cnt    = '0;
   assign bus.load_use_cnt = '0;
`endif

   assign bus.pc_write    = pc_write;
   assign bus.pc_redirect = pc_redirect;
   assign bus.pc_target   = pc_target;
   assign bus.ifid_write  = ifid_write;
   assign bus.idex_write  = idex_write;
   assign bus.exmem_write = exmem_write;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.idex_flush  = idex_flush;
   assign bus.memwb_flush = memwb_flush;
   assign bus.mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios followed by random traffic,
// all checked against a cycle-level reference model of the sequencing rules.
module tb_hazard_ctrl;

   localparam int XLEN = 32;
   localparam int MT   = 3;
   localparam int PW   = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.XLEN(XLEN), .PERF_W(PW)) bus();

   hazard_ctrl #(.XLEN(XLEN), .MEM_TIMEOUT(MT), .PERF_W(PW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   bit          m_pend;
   logic [31:0] m_tgq;
   int          m_run;
   bit          m_to;
   longint      m_stall, m_flush, m_lu;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] dut_ctl();
      return {bus.pc_write, bus.pc_redirect, bus.ifid_write, bus.idex_write,
              bus.exmem_write, bus.ifid_flush, bus.idex_flush, bus.memwb_flush};
   endfunction

   function automatic bit m_dstall();
      return bus.exmem_mem_req && !bus.dmem_ready;
   endfunction

   function automatic bit m_lu_hit();
      return bus.idex_mem_read && (bus.idex_rd != 0) &&
             ((bus.ifid_use_rs1 && bus.idex_rd == bus.ifid_rs1) ||
              (bus.ifid_use_rs2 && bus.idex_rd == bus.ifid_rs2));
   endfunction

   // {pc_write, pc_redirect, ifid_w, idex_w, exmem_w, ifid_f, idex_f, memwb_f}
   function automatic logic [7:0] m_ctl();
      bit ir;
      ir = bus.imem_ready;
      if (rst)           return 8'b0000_0111;
      if (m_pend) begin
         if (m_dstall()) return 8'b0100_0101;
         return {ir, 7'b111_1100};
      end
      if (m_dstall())       return 8'b0000_0001;
      if (bus.ex_redirect)  return {ir, ir, 6'b11_1110};
      if (m_lu_hit())       return 8'b0001_1010;
      if (!ir)              return 8'b0011_1100;
      return 8'b1011_1000;
   endfunction

   task automatic set_idle();
      bus.ifid_rs1 = 0; bus.ifid_rs2 = 0;
      bus.ifid_use_rs1 = 0; bus.ifid_use_rs2 = 0;
      bus.idex_mem_read = 0; bus.idex_rd = 0;
      bus.ex_redirect = 0; bus.ex_redirect_target = 0;
      bus.imem_ready = 1; bus.exmem_mem_req = 0; bus.dmem_ready = 1;
   endtask

   // Called just after a falling edge with inputs applied; checks, then
   // advances the model across the rising edge.
   task automatic step();
      logic [7:0]  e;
      logic [31:0] tgt;
      bit d, r, ir, l;
      #1;
      if (rst) begin
         m_pend = 0; m_tgq = 0; m_run = 0; m_to = 0;
         m_stall = 0; m_flush = 0; m_lu = 0;
      end
      e = m_ctl();
      check("ctl", {56'b0, dut_ctl()}, {56'b0, e});
      if (rst)
         check("pc_target_rst", {32'b0, bus.pc_target}, 64'd0);
      else if (e[6])
         check("pc_target", {32'b0, bus.pc_target},
               {32'b0, (m_pend ? m_tgq : bus.ex_redirect_target)});
      check("mem_timeout", {63'b0, bus.mem_timeout}, {63'b0, m_to});
`ifdef HAZARD_PERF_EN
      check("stall_cnt", {32'b0, bus.stall_cnt}, m_stall);
      check("flush_cnt", {32'b0, bus.flush_cnt}, m_flush);
      check("load_use_cnt", {32'b0, bus.load_use_cnt}, m_lu);
`else
      check("stall_cnt", {32'b0, bus.stall_cnt}, 64'd0);
      check("flush_cnt", {32'b0, bus.flush_cnt}, 64'd0);
      check("load_use_cnt", {32'b0, bus.load_use_cnt}, 64'd0);
`endif
      d = m_dstall(); r = bus.ex_redirect; ir = bus.imem_ready; l = m_lu_hit();
      tgt = bus.ex_redirect_target;
      @(posedge clk);
      if (!rst) begin
         if (!e[7]) m_stall++;
         if (!m_pend && !d && r) m_flush++;
         if (!m_pend && !d && !r && l) m_lu++;
         if (d) begin
            if (MT != 0 && m_run + 1 >= MT) m_to = 1;
            m_run++;
         end else begin
            m_run = 0;
         end
         if (!m_pend) begin
            if (!d && r && !ir) begin m_pend = 1; m_tgq = tgt; end
         end else begin
            if (r) m_tgq = tgt;
            if (ir && !d) m_pend = 0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      set_idle();
      rst = 1'b1;
      @(negedge clk);
      #1 check("reset_ctl", {56'b0, dut_ctl()}, 64'h07);
      step();
      rst = 1'b0;

      // load-use on rs2: exactly one stall cycle
      bus.idex_mem_read = 1; bus.idex_rd = 5; bus.ifid_rs2 = 5; bus.ifid_use_rs2 = 1;
      #1 check("lu_stall", {56'b0, dut_ctl()}, 64'h1A);
      step();
      bus.idex_mem_read = 0;
      #1 check("lu_release", {56'b0, dut_ctl()}, 64'hB8);
      step();

      // rd = x0 never stalls
      bus.idex_mem_read = 1; bus.idex_rd = 0; bus.ifid_rs2 = 0;
      #1 check("lu_x0", {56'b0, dut_ctl()}, 64'hB8);
      step();
      set_idle();

      // redirect with IF ready
      bus.ex_redirect = 1; bus.ex_redirect_target = 32'h100;
      #1 check("redir_ctl", {56'b0, dut_ctl()}, 64'hFE);
      check("redir_tgt", {32'b0, bus.pc_target}, 64'h100);
      step();
      set_idle();

      // redirect with IF busy for 3 cycles
      bus.ex_redirect = 1; bus.ex_redirect_target = 32'h200; bus.imem_ready = 0;
      #1 check("redir_busy", {56'b0, dut_ctl()}, 64'h3E);
      step();
      bus.ex_redirect = 0;
      for (int i = 0; i < 2; i++) begin
         #1 check("pend_wait", {56'b0, dut_ctl()}, 64'h7C);
         check("pend_tgt", {32'b0, bus.pc_target}, 64'h200);
         step();
      end
      bus.imem_ready = 1;
      #1 check("pend_take", {56'b0, dut_ctl()}, 64'hFC);
      check("pend_take_tgt", {32'b0, bus.pc_target}, 64'h200);
      step();
      #1 check("pend_back_run", {56'b0, dut_ctl()}, 64'hB8);
      step();

      // dmem wait holds a redirect; timeout after the 3rd wait cycle
      bus.exmem_mem_req = 1; bus.dmem_ready = 0;
      bus.ex_redirect = 1; bus.ex_redirect_target = 32'h300;
      for (int i = 0; i < 4; i++) begin
         #1 check("dwait_ctl", {56'b0, dut_ctl()}, 64'h01);
         check("dwait_to", {63'b0, bus.mem_timeout}, {63'b0, (i == 3)});
         step();
      end
      bus.dmem_ready = 1;
      #1 check("dwait_redir", {56'b0, dut_ctl()}, 64'hFE);
      check("dwait_tgt", {32'b0, bus.pc_target}, 64'h300);
      step();
      set_idle();
      #1 check("to_sticky", {63'b0, bus.mem_timeout}, 64'd1);
      step();

      // reset while a redirect is pending
      bus.ex_redirect = 1; bus.ex_redirect_target = 32'h400; bus.imem_ready = 0;
      step();
      bus.ex_redirect = 0;
      rst = 1'b1;
      #1 check("mid_rst_ctl", {56'b0, dut_ctl()}, 64'h07);
      check("mid_rst_to", {63'b0, bus.mem_timeout}, 64'd0);
      step();
      rst = 1'b0;
      bus.imem_ready = 1;
      #1 check("after_rst_run", {56'b0, dut_ctl()}, 64'hB8);
      step();

      // random traffic
      for (int n = 0; n < 800; n++) begin
         bus.ifid_rs1 = 5'($urandom_range(0, 3));
         bus.ifid_rs2 = 5'($urandom_range(0, 3));
         bus.ifid_use_rs1 = 1'($urandom_range(0, 1));
         bus.ifid_use_rs2 = 1'($urandom_range(0, 1));
         bus.idex_rd = 5'($urandom_range(0, 3));
         bus.idex_mem_read = ($urandom_range(0, 2) == 0);
         bus.ex_redirect = ($urandom_range(0, 5) == 0);
         bus.ex_redirect_target = $urandom & 32'hFFFF_FFFC;
         bus.imem_ready = ($urandom_range(0, 3) != 0);
         bus.exmem_mem_req = ($urandom_range(0, 1) == 0);
         bus.dmem_ready = ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
